// File: rtl/seq_burst_arbiter_pkg.sv
// seq_burst_arbiter_pkg
//   Shared definitions for the sequenced burst arbiter:
//     - FSM state encoding (IDLE / GRANT / STREAM)
//     - pattern table depth, index and length widths
//     - reset contents of the pattern table
//     - helper that maps a raw burst length to its effective beat count
package seq_burst_arbiter_pkg;

  localparam int DEPTH   = 8;
  localparam int IDX_W   = 3;
  localparam int LEN_W   = 4;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  localparam logic [7:0] DEFAULT_TABLE [DEPTH] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  // A requested length of zero stands for a full sweep of the table.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(DEPTH) : len;
  endfunction

endpackage

// File: rtl/seq_rr_picker.sv
// seq_rr_picker
//   Combinational two-way round-robin choice.
//   Ports:
//     req          - request vector, bit n set when requester n is asking
//     rr           - requester that wins when both are asking
//     grant_valid  - at least one requester is asking
//     winner       - index of the chosen requester
module seq_rr_picker
  import seq_burst_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               rr,
  output logic               grant_valid,
  output logic               winner
);

  // A lone requester always wins; a tie goes to the pointer. With no
  // request the winner output is meaningless and simply follows rr.
  always_comb begin
    grant_valid = |req;
    winner      = rr;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = rr;
      default: winner = rr;
    endcase
  end

endmodule

// File: rtl/seq_burst_arbiter.sv
// seq_burst_arbiter
//   Arbitrates two burst requesters onto one valid/ready stream. Each burst
//   walks a flop-based 8-entry pattern table from a start index for a given
//   number of beats, wrapping from entry 7 back to entry 0.
//   Ports:
//     clk, reset               - clock and synchronous active-high reset
//     req_valid / req_ack      - per-requester request and one-cycle grant pulse
//     req0_start, req1_start   - burst start index per requester
//     req0_len,   req1_len     - burst length per requester (0 means 8)
//     cfg_we, cfg_addr, cfg_data - pattern table write port
//     out_valid, out_ready     - stream handshake
//     out_data, out_id, out_last - beat payload, owning requester, last beat flag
//     busy                     - high whenever the FSM is not idle
module seq_burst_arbiter #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ack,
  input  logic [2:0]    req0_start,
  input  logic [2:0]    req1_start,
  input  logic [3:0]    req0_len,
  input  logic [3:0]    req1_len,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_id,
  output logic          out_last,
  output logic          busy
);

  import seq_burst_arbiter_pkg::*;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              id_q, id_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        req_lat_q, req_lat_d;
  logic [DW-1:0]     pat_table [DEPTH];

  logic              pick_valid;
  logic              pick_winner;

  // The request vector seen in IDLE is held for the GRANT cycle, so a
  // requester that drops its valid right after being noticed still wins.
  seq_rr_picker u_picker (
    .req         (req_lat_q),
    .rr          (rr_q),
    .grant_valid (pick_valid),
    .winner      (pick_winner)
  );

  // Pattern table held in flops. Reset reloads the defaults and wins over
  // a simultaneous configuration write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat_table[i] <= DW'(DEFAULT_TABLE[i]);
      end
    end else if (cfg_we) begin
      pat_table[cfg_addr] <= cfg_data;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_q      <= 1'b0;
      id_q      <= 1'b0;
      idx_q     <= '0;
      rem_q     <= '0;
      req_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      req_lat_q <= req_lat_d;
    end
  end

  // Next-state and handshake outputs. GRANT always lasts exactly one cycle,
  // which gives the minimum IDLE + GRANT gap between back-to-back bursts.
  // During STREAM the request inputs are not looked at.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    req_lat_d = req_lat_q;
    req_ack   = 2'b00;
    out_valid = 1'b0;
    out_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_lat_d = req_valid;
          state_d   = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (pick_valid) begin
          req_ack[pick_winner] = 1'b1;
          id_d    = pick_winner;
          idx_d   = pick_winner ? req1_start : req0_start;
          rem_d   = eff_len(pick_winner ? req1_len : req0_len);
          rr_d    = ~pick_winner;
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_STREAM: begin
        out_valid = 1'b1;
        out_last  = (rem_q == LEN_W'(1));
        if (out_ready) begin
          idx_d = idx_q + IDX_W'(1);
          rem_d = rem_q - LEN_W'(1);
          if (out_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Data is read straight from the table through the registered index, so
  // a write to the entry being presented shows up on the following cycle.
  assign out_data = pat_table[idx_q];
  assign out_id   = (state_q == ST_STREAM) & id_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_burst_arbiter.sv
module tb_seq_burst_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ack;
  logic [2:0]    req0_start, req1_start;
  logic [3:0]    req0_len, req1_len;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_id;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  seq_burst_arbiter #(.DW(DW), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ack    (req_ack),
    .req0_start (req0_start),
    .req1_start (req1_start),
    .req0_len   (req0_len),
    .req1_len   (req1_len),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a burst is described by its start, length, owner and
  // number of beats already delivered; the data of the beat on offer is
  // looked up in the model's own copy of the table.
  logic [7:0] def_table [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
  logic [7:0] m_table [8];
  bit         m_init = 1'b0;
  bit         m_granting = 1'b0;
  bit         m_streaming = 1'b0;
  bit         m_after_reset = 1'b0;
  logic [1:0] m_lat = 2'b00;
  int         m_rr = 0;
  int         b_id = 0, b_start = 0, b_len = 0, b_sent = 0;
  logic [7:0] beat_data [$];
  int         beat_id [$];
  int         grant_log [$];

  function automatic int pick(input logic [1:0] lat, input int rr);
    if (lat == 2'b11) return rr;
    return lat[1] ? 1 : 0;
  endfunction

  function automatic logic [7:0] model_beat();
    logic [2:0] ix;
    ix = 3'((b_start + b_sent) % 8);
    return m_table[ix];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      foreach (m_table[i]) m_table[i] = def_table[i];
      m_rr          = 0;
      m_granting    = 1'b0;
      m_streaming   = 1'b0;
      m_after_reset = 1'b1;
      m_init        = 1'b1;
    end else if (m_init) begin
      if (m_streaming) begin
        if (out_ready) begin
          beat_data.push_back(model_beat());
          beat_id.push_back(b_id);
          b_sent++;
          if (b_sent == b_len) m_streaming = 1'b0;
        end
      end else if (m_granting) begin
        b_id    = pick(m_lat, m_rr);
        b_start = b_id == 1 ? int'(req1_start) : int'(req0_start);
        b_len   = b_id == 1 ? int'(req1_len) : int'(req0_len);
        if (b_len == 0) b_len = 8;
        b_sent  = 0;
        m_rr    = 1 - b_id;
        grant_log.push_back(b_id);
        m_granting    = 1'b0;
        m_streaming   = 1'b1;
        m_after_reset = 1'b0;
      end else if (req_valid != 2'b00) begin
        m_granting = 1'b1;
        m_lat      = req_valid;
      end
      if (cfg_we) m_table[cfg_addr] = cfg_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] e_ack;
    e_ack = 2'b00;
    if (m_granting) e_ack[pick(m_lat, m_rr)] = 1'b1;
    check("out_valid", 32'(out_valid), 32'(m_streaming));
    check("req_ack", 32'(req_ack), 32'(e_ack));
    check("busy", 32'(busy), 32'(m_streaming | m_granting));
    check("out_last", 32'(out_last), 32'(m_streaming && (b_sent == b_len - 1)));
    check("out_id", 32'(out_id), m_streaming ? 32'(b_id) : 32'(0));
    if (m_streaming) check("out_data", 32'(out_data), 32'(model_beat()));
    else if (m_after_reset) check("out_data_idle", 32'(out_data), 32'(m_table[0]));
  endtask

  always @(negedge clk) begin
    if (m_init) checkOutput();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents a one-cycle request and then withdraws it.
  task automatic applyStimulus(input logic [1:0] rv, input logic [2:0] s0, input logic [3:0] l0,
                               input logic [2:0] s1, input logic [3:0] l1);
    req0_start = s0;
    req0_len   = l0;
    req1_start = s1;
    req1_len   = l1;
    req_valid  = rv;
    tick();
    req_valid  = 2'b00;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while ((m_streaming || m_granting) && n < budget) begin
      tick();
      n++;
    end
    if (m_streaming || m_granting) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout after %0d cycles", name, budget);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic checkBeats(input string name, input int first, input logic [7:0] ed [$], input int ei [$]);
    check({name, "_count"}, 32'(beat_data.size() - first), 32'(ed.size()));
    for (int k = 0; k < ed.size(); k++) begin
      if (first + k < beat_data.size()) begin
        check({name, "_data"}, 32'(beat_data[first + k]), 32'(ed[k]));
        check({name, "_id"}, 32'(beat_id[first + k]), 32'(ei[k]));
      end
    end
  endtask

  initial begin
    int base;
    int gbase;
    int n;
    logic [7:0] ed [$];
    int ei [$];

    reset = 1'b1; req_valid = 2'b00;
    req0_start = 3'd0; req1_start = 3'd0; req0_len = 4'd0; req1_len = 4'd0;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // Scenario 1: single short burst, first-beat latency, request withdrawn early.
    base = beat_data.size();
    req0_start = 3'd0; req0_len = 4'd3; req_valid = 2'b01;
    n = 0;
    do begin
      tick();
      n++;
      req_valid = 2'b00;
    end while (!out_valid && n < 10);
    check("first_beat_latency", 32'(n), 32'(2));
    waitIdle("s1", 20);
    ed = '{8'hAF, 8'hBC, 8'hE2}; ei = '{0, 0, 0};
    checkBeats("s1", base, ed, ei);

    // Scenario 2: both requesters held, round-robin alternation with wrap.
    doReset();
    base = beat_data.size(); gbase = grant_log.size();
    req0_start = 3'd0; req0_len = 4'd1; req1_start = 3'd6; req1_len = 4'd4;
    req_valid = 2'b11;
    n = 0;
    while (grant_log.size() - gbase < 4 && n < 100) begin
      tick();
      n++;
    end
    req_valid = 2'b00;
    waitIdle("s2", 30);
    check("s2_grant_count", 32'(grant_log.size() - gbase), 32'(4));
    for (int k = 0; k < 4; k++) begin
      if (gbase + k < grant_log.size()) check("s2_grant_order", 32'(grant_log[gbase + k]), 32'(k % 2));
    end
    ed = '{8'hAF, 8'h0B, 8'h8D, 8'hAF, 8'hBC, 8'hAF, 8'h0B, 8'h8D, 8'hAF, 8'hBC};
    ei = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    checkBeats("s2", base, ed, ei);

    // Scenario 3: length 0 from start 5 sweeps the whole table.
    base = beat_data.size();
    applyStimulus(2'b01, 3'd5, 4'd0, 3'd0, 4'd1);
    waitIdle("s3", 30);
    ed = '{8'hE2, 8'h0B, 8'h8D, 8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    checkBeats("s3", base, ed, ei);

    // Scenario 4: stalls mid-burst.
    base = beat_data.size();
    applyStimulus(2'b10, 3'd0, 4'd1, 3'd2, 4'd4);
    tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1;
    waitIdle("s4", 20);
    ed = '{8'hE2, 8'h78, 8'hFF, 8'hE2}; ei = '{1, 1, 1, 1};
    checkBeats("s4", base, ed, ei);

    // Scenario 5: table writes before the burst and onto the entry on offer.
    base = beat_data.size();
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 8'h55;
    applyStimulus(2'b01, 3'd0, 4'd5, 3'd0, 4'd1);
    cfg_we = 1'b0;
    n = 0;
    while (!(m_streaming && b_sent == 3) && n < 20) begin
      tick();
      n++;
    end
    out_ready = 1'b0; cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 8'h66;
    tick();
    cfg_we = 1'b0; out_ready = 1'b1;
    waitIdle("s5", 20);
    ed = '{8'hAF, 8'hBC, 8'h55, 8'h66, 8'hFF}; ei = '{0, 0, 0, 0, 0};
    checkBeats("s5", base, ed, ei);

    // Scenario 6: reset on the second beat aborts the burst and restores the table.
    base = beat_data.size();
    applyStimulus(2'b01, 3'd0, 4'd5, 3'd0, 4'd1);
    n = 0;
    while (!(m_streaming && b_sent == 1) && n < 20) begin
      tick();
      n++;
    end
    doReset();
    check("s6_valid_after_reset", 32'(out_valid), 32'(0));
    ed = '{8'hAF}; ei = '{0};
    checkBeats("s6_abort", base, ed, ei);
    base = beat_data.size();
    applyStimulus(2'b01, 3'd0, 4'd0, 3'd0, 4'd1);
    waitIdle("s6", 30);
    ed = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    checkBeats("s6_restored", base, ed, ei);

    // Randomised traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid  = 2'($urandom_range(0, 3));
      req0_start = 3'($urandom_range(0, 7));
      req1_start = 3'($urandom_range(0, 7));
      req0_len   = 4'($urandom_range(0, 8));
      req1_len   = 4'($urandom_range(0, 8));
      out_ready  = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 15) == 0);
      cfg_addr   = 3'($urandom_range(0, 7));
      cfg_data   = 8'($urandom_range(0, 255));
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; req_valid = 2'b00; cfg_we = 1'b0; out_ready = 1'b1;
    waitIdle("random_drain", 30);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
